// File: rtl/t_stream_buffer_pkg.sv
// rtl/t_stream_buffer_pkg.sv - shared constants, nucleotide codes and state encoding for the T stream buffer
package t_stream_buffer_pkg;

    // Score width used across the codebase; the buffer width must track it.
    localparam int V_E_F_Bit    = 16;
    localparam int TBUF_VEF_W   = V_E_F_Bit;

    // Depth of the target-sequence store.
    localparam int TBUF_MAX_LEN = 1024;
    localparam int TBUF_ADDR_W  = $clog2(TBUF_MAX_LEN);

    typedef enum logic [1:0] {
        NUC_A = 2'd0,
        NUC_C = 2'd1,
        NUC_G = 2'd2,
        NUC_T = 2'd3
    } nuc_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_READY = 2'd2,
        ST_PASS  = 2'd3
    } tbuf_state_e;

endpackage

// File: rtl/tbuf_ram.sv
// rtl/tbuf_ram.sv - simple dual-port entry store with bit-masked write and registered read
module tbuf_ram #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 35
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wmask,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Masked write: only the bits selected by i_wmask are replaced, so writeback
    // can update the scores without touching the nucleotide and last flag.
    always_ff @(posedge clk) begin
        if (i_we) begin
            mem_q[i_waddr] <= (mem_q[i_waddr] & ~i_wmask) | (i_wdata & i_wmask);
        end
    end

    // Synchronous read; on a same-address write the old word is returned.
    always_ff @(posedge clk) begin
        if (i_re) begin
            rdata_q <= mem_q[i_raddr];
        end
    end

    assign o_rdata = rdata_q;

endmodule

// File: rtl/t_stream_buffer.sv
// rtl/t_stream_buffer.sv - target-sequence stream buffer feeding the PE array T port
module t_stream_buffer
    import t_stream_buffer_pkg::*;
#(
    parameter int T_MAX_LEN = TBUF_MAX_LEN,
    parameter int ADDR_W    = TBUF_ADDR_W,
    parameter int VEF_W     = TBUF_VEF_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load_valid,
    input  logic [1:0]       i_load_t,
    input  logic             i_load_last,
    output logic             o_load_ready,
    input  logic             i_pass_start,
    output logic             o_data_valid,
    output logic [1:0]       o_t,
    output logic [VEF_W-1:0] o_v,
    output logic [VEF_W-1:0] o_f,
    output logic             o_t_last,
    input  logic             i_t_req,
    input  logic             i_wb_valid,
    input  logic [1:0]       i_wb_t,
    input  logic [VEF_W-1:0] i_wb_v,
    input  logic [VEF_W-1:0] i_wb_f,
    output logic [ADDR_W:0]  o_len,
    output logic             o_busy,
    output logic             o_pass_done,
    output logic             o_err
);

    // Entry layout in the store: {t[1:0], last, v, f}
    localparam int ENTRY_W  = 3 + 2 * VEF_W;
    localparam int T_LSB    = 2 * VEF_W + 1;
    localparam int LAST_BIT = 2 * VEF_W;
    localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W + 1)'(T_MAX_LEN);

    tbuf_state_e state_q, state_d;

    logic [ADDR_W:0] len_q, len_d;
    logic [ADDR_W:0] rd_q, rd_d;      // entries consumed this pass
    logic [ADDR_W:0] wr_q, wr_d;      // entries written back this pass
    logic            valid_q, valid_d;
    logic            err_q, err_d;
    logic            done_q, done_d;

    logic [ADDR_W:0] len_inc;
    logic [ADDR_W:0] rd_inc;
    logic [ADDR_W:0] wr_inc;

    logic            load_accept;
    logic            load_overflow;
    logic            pass_start;
    logic            req_fire;
    logic            wb_seen;
    logic            wb_ok;
    logic            wb_final;
    logic [1:0]      wb_stored_t;

    logic               ram_we;
    logic [ADDR_W-1:0]  ram_waddr;
    logic [ENTRY_W-1:0] ram_wmask;
    logic [ENTRY_W-1:0] ram_wdata;
    logic               ram_re;
    logic [ADDR_W-1:0]  ram_raddr;
    logic [ENTRY_W-1:0] ram_rdata;

    // Copy of the loaded nucleotides, readable in the writeback cycle so the
    // controller's echoed t can be checked without a second RAM read port.
    logic [1:0] t_shadow_q [T_MAX_LEN];

    assign len_inc = len_q + 1'b1;
    assign rd_inc  = rd_q + 1'b1;
    assign wr_inc  = wr_q + 1'b1;

    assign load_accept   = i_load_valid &&
                           ((state_q == ST_IDLE) || ((state_q == ST_LOAD) && (len_q != MAX_LEN)));
    assign load_overflow = i_load_valid && (state_q == ST_LOAD) && (len_q == MAX_LEN);
    assign pass_start    = i_pass_start && (state_q == ST_READY);
    assign req_fire      = i_t_req && valid_q;
    assign wb_seen       = i_wb_valid && (state_q == ST_PASS);
    // Writeback must target an already-consumed entry, which also keeps the
    // write address strictly below the next read address.
    assign wb_ok         = (wr_q < rd_q) && (wr_q < len_q);
    assign wb_final      = wb_seen && wb_ok && (wr_inc == len_q);
    assign wb_stored_t   = t_shadow_q[wr_q[ADDR_W-1:0]];

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (i_load_valid) begin
                    state_d = i_load_last ? ST_READY : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (load_overflow || (i_load_valid && i_load_last)) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                if (pass_start) begin
                    state_d = ST_PASS;
                end
            end
            ST_PASS: begin
                if (wb_final) begin
                    state_d = ST_READY;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs decoded from the current state
    always_comb begin
        o_load_ready = 1'b0;
        o_busy       = 1'b0;
        case (state_q)
            ST_IDLE:  o_load_ready = 1'b1;
            ST_LOAD: begin
                o_load_ready = 1'b1;
                o_busy       = 1'b1;
            end
            ST_PASS:  o_busy = 1'b1;
            default: begin
                o_load_ready = 1'b0;
                o_busy       = 1'b0;
            end
        endcase
    end

    // Pointer, prefetch, error and RAM port control
    always_comb begin
        len_d     = len_q;
        rd_d      = rd_q;
        wr_d      = wr_q;
        valid_d   = valid_q;
        err_d     = err_q;
        done_d    = 1'b0;
        ram_we    = 1'b0;
        ram_waddr = len_q[ADDR_W-1:0];
        ram_wmask = '0;
        ram_wdata = '0;
        ram_re    = 1'b0;
        ram_raddr = '0;

        if (load_accept) begin
            ram_we    = 1'b1;
            ram_waddr = len_q[ADDR_W-1:0];
            ram_wmask = '1;
            ram_wdata = {i_load_t, i_load_last, {(2 * VEF_W){1'b0}}};
            len_d     = len_inc;
        end

        if (load_overflow) begin
            err_d = 1'b1;
        end

        // Prime the prefetch register with entry 0 so it shows one cycle later.
        if (pass_start) begin
            rd_d      = '0;
            wr_d      = '0;
            valid_d   = 1'b1;
            ram_re    = 1'b1;
            ram_raddr = '0;
        end

        // Consuming an entry fetches the next one; the read-data register holds
        // the current entry while no request is made.
        if (req_fire) begin
            rd_d = rd_inc;
            if (rd_inc < len_q) begin
                ram_re    = 1'b1;
                ram_raddr = rd_inc[ADDR_W-1:0];
            end else begin
                valid_d = 1'b0;
            end
        end

        if (wb_seen) begin
            if (!wb_ok) begin
                err_d = 1'b1;
            end else begin
                ram_we    = 1'b1;
                ram_waddr = wr_q[ADDR_W-1:0];
                ram_wmask = {3'b000, {(2 * VEF_W){1'b1}}};
                ram_wdata = {3'b000, i_wb_v, i_wb_f};
                wr_d      = wr_inc;
                if (i_wb_t != wb_stored_t) begin
                    err_d = 1'b1;
                end
                if (wr_inc == len_q) begin
                    done_d = 1'b1;
                end
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q   <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            len_q   <= len_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    // Nucleotide shadow, written alongside each accepted load
    always_ff @(posedge clk) begin
        if (load_accept) begin
            t_shadow_q[len_q[ADDR_W-1:0]] <= i_load_t;
        end
    end

    tbuf_ram #(
        .DEPTH  (T_MAX_LEN),
        .ADDR_W (ADDR_W),
        .DATA_W (ENTRY_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (ram_we),
        .i_waddr (ram_waddr),
        .i_wmask (ram_wmask),
        .i_wdata (ram_wdata),
        .i_re    (ram_re),
        .i_raddr (ram_raddr),
        .o_rdata (ram_rdata)
    );

    // Entry fields are forced to zero whenever no valid entry is presented.
    assign o_data_valid = valid_q;
    assign o_t          = valid_q ? ram_rdata[ENTRY_W-1:T_LSB]     : 2'b00;
    assign o_t_last     = valid_q ? ram_rdata[LAST_BIT]            : 1'b0;
    assign o_v          = valid_q ? ram_rdata[2*VEF_W-1:VEF_W]     : '0;
    assign o_f          = valid_q ? ram_rdata[VEF_W-1:0]           : '0;
    assign o_len        = len_q;
    assign o_pass_done  = done_q;
    assign o_err        = err_q;

endmodule

// File: tb/tb_t_stream_buffer.sv
// tb/tb_t_stream_buffer.sv - directed self-checking bench for t_stream_buffer
module tb_t_stream_buffer;
    import t_stream_buffer_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_load_valid = 1'b0;
    logic [1:0]  i_load_t = 2'b0;
    logic        i_load_last = 1'b0;
    logic        o_load_ready;
    logic        i_pass_start = 1'b0;
    logic        o_data_valid;
    logic [1:0]  o_t;
    logic [15:0] o_v;
    logic [15:0] o_f;
    logic        o_t_last;
    logic        i_t_req = 1'b0;
    logic        i_wb_valid = 1'b0;
    logic [1:0]  i_wb_t = 2'b0;
    logic [15:0] i_wb_v = 16'h0;
    logic [15:0] i_wb_f = 16'h0;
    logic [10:0] o_len;
    logic        o_busy;
    logic        o_pass_done;
    logic        o_err;

    int n_vec = 0;
    int n_err = 0;

    t_stream_buffer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_load_valid (i_load_valid),
        .i_load_t     (i_load_t),
        .i_load_last  (i_load_last),
        .o_load_ready (o_load_ready),
        .i_pass_start (i_pass_start),
        .o_data_valid (o_data_valid),
        .o_t          (o_t),
        .o_v          (o_v),
        .o_f          (o_f),
        .o_t_last     (o_t_last),
        .i_t_req      (i_t_req),
        .i_wb_valid   (i_wb_valid),
        .i_wb_t       (i_wb_t),
        .i_wb_v       (i_wb_v),
        .i_wb_f       (i_wb_f),
        .o_len        (o_len),
        .o_busy       (o_busy),
        .o_pass_done  (o_pass_done),
        .o_err        (o_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        i_load_valid = 1'b0; i_load_t = 2'b0; i_load_last = 1'b0;
        i_pass_start = 1'b0; i_t_req = 1'b0;
        i_wb_valid = 1'b0; i_wb_t = 2'b0; i_wb_v = 16'h0; i_wb_f = 16'h0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic load_entry(input logic [1:0] t, input logic last);
        i_load_valid = 1'b1; i_load_t = t; i_load_last = last;
        tick();
        i_load_valid = 1'b0; i_load_last = 1'b0;
    endtask

    task automatic start_pass();
        i_pass_start = 1'b1;
        tick();
        i_pass_start = 1'b0;
    endtask

    task automatic wb_entry(input logic [1:0] t, input logic [15:0] v, input logic [15:0] f);
        i_wb_valid = 1'b1; i_wb_t = t; i_wb_v = v; i_wb_f = f;
        tick();
        i_wb_valid = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if ({o_data_valid, o_t, o_v, o_f, o_t_last, o_len, o_busy, o_pass_done, o_err} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got valid=%0b t=%0d v=%0h f=%0h last=%0b len=%0d busy=%0b done=%0b err=%0b, expected all 0",
                     o_data_valid, o_t, o_v, o_f, o_t_last, o_len, o_busy, o_pass_done, o_err);
        end
        n_vec++;
        if (o_load_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_load_ready: got %0b expected 1", o_load_ready);
        end
        rst_n = 1'b1;
        tick();
        n_vec++;
        if ({o_load_ready, o_len, o_busy} !== {1'b1, 11'd0, 1'b0}) begin
            n_err++;
            $display("FAIL post_reset_idle: got ready=%0b len=%0d busy=%0b expected 1/0/0", o_load_ready, o_len, o_busy);
        end
    endtask

    // Load A,C,G,T and stream them with i_t_req held high.
    task automatic test_stream();
        load_entry(NUC_A, 1'b0);
        load_entry(NUC_C, 1'b0);
        load_entry(NUC_G, 1'b0);
        load_entry(NUC_T, 1'b1);
        n_vec++;
        if ({o_len, o_busy, o_load_ready} !== {11'd4, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL load4_ready_state: got len=%0d busy=%0b ready=%0b expected 4/0/0", o_len, o_busy, o_load_ready);
        end
        start_pass();
        i_t_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n_vec++;
            if ({o_data_valid, o_t, o_v, o_f, o_t_last} !== {1'b1, 2'(k), 16'd0, 16'd0, (k == 3)}) begin
                n_err++;
                $display("FAIL stream1_entry%0d: got valid=%0b t=%0d v=%0h f=%0h last=%0b expected 1/%0d/0/0/%0b",
                         k, o_data_valid, o_t, o_v, o_f, o_t_last, k, (k == 3));
            end
            tick();
        end
        i_t_req = 1'b0;
        n_vec++;
        if ({o_data_valid, o_busy} !== 2'b01) begin
            n_err++;
            $display("FAIL stream1_end: got valid=%0b busy=%0b expected 0/1", o_data_valid, o_busy);
        end
    endtask

    // Write back v=5,9,2,7 f=1 and check pass 2 returns them.
    task automatic test_writeback();
        int vexp [4] = '{5, 9, 2, 7};
        for (int k = 0; k < 4; k++) begin
            wb_entry(2'(k), 16'(vexp[k]), 16'd1);
            n_vec++;
            if (o_pass_done !== (k == 3)) begin
                n_err++;
                $display("FAIL wb%0d_pass_done: got %0b expected %0b", k, o_pass_done, (k == 3));
            end
        end
        tick();
        n_vec++;
        if ({o_pass_done, o_err, o_busy} !== 3'b000) begin
            n_err++;
            $display("FAIL after_pass1: got done=%0b err=%0b busy=%0b expected 0/0/0", o_pass_done, o_err, o_busy);
        end
        start_pass();
        i_t_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n_vec++;
            if ({o_data_valid, o_t, o_v, o_f, o_t_last} !== {1'b1, 2'(k), 16'(vexp[k]), 16'd1, (k == 3)}) begin
                n_err++;
                $display("FAIL stream2_entry%0d: got valid=%0b t=%0d v=%0d f=%0d last=%0b expected 1/%0d/%0d/1/%0b",
                         k, o_data_valid, o_t, o_v, o_f, o_t_last, k, vexp[k], (k == 3));
            end
            tick();
        end
        i_t_req = 1'b0;
    endtask

    // Close pass 2, then issue a writeback before anything is consumed.
    task automatic test_early_wb();
        int vexp [4] = '{5, 9, 2, 7};
        for (int k = 0; k < 4; k++) wb_entry(2'(k), 16'(vexp[k]), 16'd1);
        n_vec++;
        if ({o_pass_done, o_err} !== 2'b10) begin
            n_err++;
            $display("FAIL pass2_close: got done=%0b err=%0b expected 1/0", o_pass_done, o_err);
        end
        start_pass();
        wb_entry(NUC_A, 16'h00AA, 16'h00BB);
        n_vec++;
        if (o_err !== 1'b1) begin
            n_err++;
            $display("FAIL early_wb_err: got %0b expected 1", o_err);
        end
        i_t_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n_vec++;
            if ({o_t, o_v, o_f} !== {2'(k), 16'(vexp[k]), 16'd1}) begin
                n_err++;
                $display("FAIL early_wb_mem%0d: got t=%0d v=%0h f=%0h expected %0d/%0h/1", k, o_t, o_v, o_f, k, vexp[k]);
            end
            tick();
        end
        i_t_req = 1'b0;
        n_vec++;
        if (o_err !== 1'b1) begin
            n_err++;
            $display("FAIL err_sticky: got %0b expected 1", o_err);
        end
    endtask

    // 1025 loads without last: the last is dropped and flagged.
    task automatic test_overflow();
        apply_reset();
        n_vec++;
        if (o_err !== 1'b0) begin
            n_err++;
            $display("FAIL reset_clears_err: got %0b expected 0", o_err);
        end
        for (int i = 0; i < 1024; i++) load_entry(2'(i), 1'b0);
        n_vec++;
        if ({o_len, o_load_ready, o_err} !== {11'd1024, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL full_1024: got len=%0d ready=%0b err=%0b expected 1024/1/0", o_len, o_load_ready, o_err);
        end
        load_entry(NUC_A, 1'b0);
        n_vec++;
        if ({o_len, o_load_ready, o_busy, o_err} !== {11'd1024, 1'b0, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL overflow_1025: got len=%0d ready=%0b busy=%0b err=%0b expected 1024/0/0/1",
                     o_len, o_load_ready, o_busy, o_err);
        end
        load_entry(NUC_C, 1'b1);
        n_vec++;
        if (o_len !== 11'd1024) begin
            n_err++;
            $display("FAIL ready_ignores_load: got len=%0d expected 1024", o_len);
        end
        start_pass();
        i_t_req = 1'b1;
        for (int k = 0; k < 1024; k++) begin
            if (k == 1023) begin
                n_vec++;
                if ({o_data_valid, o_t, o_t_last} !== {1'b1, 2'd3, 1'b0}) begin
                    n_err++;
                    $display("FAIL full_last_entry: got valid=%0b t=%0d last=%0b expected 1/3/0", o_data_valid, o_t, o_t_last);
                end
            end
            tick();
        end
        i_t_req = 1'b0;
        n_vec++;
        if (o_data_valid !== 1'b0) begin
            n_err++;
            $display("FAIL full_stream_end: got valid=%0b expected 0", o_data_valid);
        end
    endtask

    // Request on alternate cycles, writebacks two entries behind, then flush.
    task automatic test_interleave();
        logic [1:0] tseq [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        int  cons = 0;
        int  wrn = 0;
        int  dones = 0;
        logic req_now;
        logic wb_now;
        apply_reset();
        for (int i = 0; i < 6; i++) load_entry(tseq[i], (i == 5));
        start_pass();
        for (int c = 0; c < 40 && wrn < 6; c++) begin
            req_now = ((c % 2) == 0) && (cons < 6);
            wb_now  = (wrn + 2 <= cons) || (cons == 6 && wrn < 6);
            if (req_now) begin
                n_vec++;
                if ({o_data_valid, o_t, o_t_last} !== {1'b1, tseq[cons], (cons == 5)}) begin
                    n_err++;
                    $display("FAIL interleave_entry%0d: got valid=%0b t=%0d last=%0b expected 1/%0d/%0b",
                             cons, o_data_valid, o_t, o_t_last, tseq[cons], (cons == 5));
                end
            end
            i_t_req    = req_now;
            i_wb_valid = wb_now;
            i_wb_t     = tseq[wrn % 6];
            i_wb_v     = 16'(100 + wrn);
            i_wb_f     = 16'(200 + wrn);
            tick();
            if (req_now) cons++;
            if (wb_now) wrn++;
            if (o_pass_done) dones++;
        end
        clear_inputs();
        tick();
        if (o_pass_done) dones++;
        n_vec++;
        if (wrn !== 6) begin
            n_err++;
            $display("FAIL interleave_budget: got %0d writebacks expected 6", wrn);
        end
        n_vec++;
        if ({dones, o_err, o_busy} !== {32'd1, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL interleave_done: got dones=%0d err=%0b busy=%0b expected 1/0/0", dones, o_err, o_busy);
        end
        start_pass();
        i_t_req = 1'b1;
        for (int k = 0; k < 6; k++) begin
            n_vec++;
            if ({o_t, o_v, o_f} !== {tseq[k], 16'(100 + k), 16'(200 + k)}) begin
                n_err++;
                $display("FAIL interleave_pass2_%0d: got t=%0d v=%0d f=%0d expected %0d/%0d/%0d",
                         k, o_t, o_v, o_f, tseq[k], 100 + k, 200 + k);
            end
            tick();
        end
        i_t_req = 1'b0;
    endtask

    // Asynchronous reset mid-pass, reload, and a writeback with a wrong t.
    task automatic test_reset_mid_pass();
        apply_reset();
        load_entry(NUC_A, 1'b0);
        load_entry(NUC_C, 1'b0);
        load_entry(NUC_G, 1'b1);
        start_pass();
        i_t_req = 1'b1;
        tick();
        tick();
        i_t_req = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({o_data_valid, o_t, o_v, o_f, o_t_last, o_len, o_busy, o_pass_done, o_err, o_load_ready} !== {46'd0, 1'b1}) begin
            n_err++;
            $display("FAIL midpass_reset: got valid=%0b t=%0d len=%0d busy=%0b err=%0b ready=%0b expected 0/0/0/0/0/1",
                     o_data_valid, o_t, o_len, o_busy, o_err, o_load_ready);
        end
        tick();
        rst_n = 1'b1;
        tick();
        load_entry(NUC_G, 1'b0);
        load_entry(NUC_T, 1'b1);
        n_vec++;
        if (o_len !== 11'd2) begin
            n_err++;
            $display("FAIL reload_len: got %0d expected 2", o_len);
        end
        start_pass();
        i_t_req = 1'b1;
        n_vec++;
        if ({o_data_valid, o_t, o_t_last} !== {1'b1, 2'd2, 1'b0}) begin
            n_err++;
            $display("FAIL reload_entry0: got valid=%0b t=%0d last=%0b expected 1/2/0", o_data_valid, o_t, o_t_last);
        end
        tick();
        n_vec++;
        if ({o_data_valid, o_t, o_t_last} !== {1'b1, 2'd3, 1'b1}) begin
            n_err++;
            $display("FAIL reload_entry1: got valid=%0b t=%0d last=%0b expected 1/3/1", o_data_valid, o_t, o_t_last);
        end
        tick();
        i_t_req = 1'b0;
        wb_entry(NUC_T, 16'h1234, 16'h5678);
        n_vec++;
        if ({o_err, o_pass_done} !== 2'b10) begin
            n_err++;
            $display("FAIL wb_t_mismatch: got err=%0b done=%0b expected 1/0", o_err, o_pass_done);
        end
        wb_entry(NUC_T, 16'h0001, 16'h0002);
        n_vec++;
        if (o_pass_done !== 1'b1) begin
            n_err++;
            $display("FAIL reload_pass_done: got %0b expected 1", o_pass_done);
        end
        tick();
        start_pass();
        n_vec++;
        if ({o_t, o_v, o_f} !== {2'd2, 16'h1234, 16'h5678}) begin
            n_err++;
            $display("FAIL mismatch_wb_written: got t=%0d v=%0h f=%0h expected 2/1234/5678", o_t, o_v, o_f);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_writeback();
        test_early_wb();
        test_overflow();
        test_interleave();
        test_reset_mid_pass();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
